traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Independent safety checker on the lamp side of the traffic light controller. Each cycle it observes the six lamp drive signals for road A and road B. It checks for illegal lamp patterns, conflicting right-of-way, illegal colour sequences and short yellow or all-red intervals. On the first violation it latches a fault code and drives a flashing-red override request, which the top level uses to force both roads to flashing red.

## Interface
- TICK_CYCLES, 100_000_000, clock cycles per internal monitor tick (1 s at 100 MHz)
- MIN_YELLOW, 1, minimum observed ticks a yellow must be held
- MIN_ALLRED, 1, minimum observed ticks of both-red before any green
- MAX_PHASE, 15, watchdog limit in ticks for an unchanged lamp vector
- CLK100MHZ  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- roadA_RedLight, roadA_YellowLight, roadA_GreenLight  in  1 each  road A lamp drives
- roadB_RedLight, roadB_YellowLight, roadB_GreenLight  in  1 each  road B lamp drives
- faultClear  in  1  single-cycle request to leave FAULT
- fault  out  1  latched fault flag
- faultCode  out  3  latched cause, 0 = none
- flashRed  out  1  override request; toggles each tick while in FAULT
- armed  out  1  high while in MONITOR
- phaseSeconds  out  4  ticks since the last lamp-vector change, saturating at 15

## Operation
- Input stage: the 6-bit lamp vector is registered into `cur`. The previous `cur` is held in `prev`. `chg = (cur != prev)`.
- Prescaler:
  - free-runs 0..TICK_CYCLES-1.
  - `tick` is asserted for one cycle at wrap.
- Phase timer:
  - cleared to 0 on `chg`.
  - otherwise increments on `tick`, saturating at 15.
  - Drives `phaseSeconds`.
- States: INIT, MONITOR, FAULT.
  - INIT → MONITOR: when `cur` is both-red (R only on A and B). No checks run in INIT.
  - MONITOR → FAULT: on any detected violation.
  - FAULT → INIT: on faultClear.
  - FAULT with no faultClear: stays in FAULT.
- Checks in MONITOR, evaluated on `cur`/`prev`. Codes are listed in priority order; the lowest code wins when several are detected in the same cycle:
  - 1 conflict: neither road shows R only.
  - 2 lamp: either road is not one-hot (none lit, or two or more lit).
  - 3 sequence: a per-road change other than G→Y, Y→R or R→G.
  - 4 short yellow: a road leaves Y with phase timer < MIN_YELLOW.
  - 5 short all-red: a road enters G with phase timer < MIN_ALLRED. The timer here measures the both-red interval, because the other road is red throughout.
  - 6 watchdog: phase timer reaches MAX_PHASE with no change.
- Latching:
  - fault and faultCode latch on entry to FAULT.
  - Later violations do not overwrite faultCode.
- flashRed:
  - set to 1 on entry to FAULT.
  - toggles on each `tick` while in FAULT.
  - 0 in all other states.
- faultClear:
  - ignored outside FAULT.
  - On leaving FAULT, fault, faultCode and flashRed are all cleared.
- Timing granularity is ±1 tick, because the monitor prescaler is not phase-aligned to the controller. MIN_* values are therefore expressed in observed ticks.

## Timing
- Reset values:
  - state INIT; fault 0; faultCode 0; flashRed 0; armed 0.
  - phaseSeconds 0; prescaler 0; `cur` and `prev` 0.
- Latency:
  - A lamp input change at edge k is sampled into `cur` at edge k+1.
  - fault, faultCode and the state change to FAULT are registered at edge k+2.
- armed rises at the edge after both-red is first sampled in INIT.
- faultClear sampled high at edge k: state is INIT and fault is 0 after edge k.
- faultClear and a new violation in the same cycle: faultClear wins. The new violation is not checked, because INIT performs no checks.
- reset asserted in any state returns everything to reset values at the next edge.
- Phase timer wrap: saturation at 15 prevents wrap to 0.
- `chg` and `tick` in the same cycle: the timer clears to 0, with no increment.

## Configuration
- MONITOR_WATCHDOG_EN
  - Defined: check 6 is compiled in and MAX_PHASE is used.
  - Undefined: the watchdog logic is absent, faultCode never equals 6, and MAX_PHASE is ignored. The phase timer still saturates at 15.

## Test plan
All scenarios use TICK_CYCLES=10.
- Legal cycle → armed 1, fault 0 throughout.
  - Reset, drive both-red for 20 cycles, then greenA 40, yellowA 20, redA 20, greenB 40, yellowB 20, redB 20.
- Conflict → faultCode 1.
  - Drive A=G, B=G from MONITOR.
  - fault 1 and faultCode 1 exactly 2 edges after the input change.
  - flashRed toggles every 10 cycles.
- Skipped yellow → faultCode 3.
  - Road A changes G→R directly, with B red throughout.
- Short yellow → faultCode 4.
  - A holds Y for 3 cycles, with no tick elapsed, then changes to R.
- Simultaneous violations → faultCode 1, showing that priority beats the lower-priority codes.
  - Drive A={R,G} and B=G in the same cycle.
- Watchdog and clear sequencing, with the macro defined → faultCode 6.
  - Hold greenA/redB for 160 cycles.
  - Pulse faultClear while greenA is held → state INIT, armed 0.
  - Drive both-red → armed 1.
  - With the macro undefined, the same hold gives fault 0.

Source files
------------

// File: rtl/traffic_conflict_monitor_if.sv
// traffic_conflict_monitor_if: lamp drives, fault clear request and monitor status bundle
interface traffic_conflict_monitor_if;
    logic roadA_RedLight, roadA_YellowLight, roadA_GreenLight;
    logic roadB_RedLight, roadB_YellowLight, roadB_GreenLight;
    logic faultClear;
    logic fault;
    logic [2:0] faultCode;
    logic flashRed;
    logic armed;
    logic [3:0] phaseSeconds;
    modport master (
        output roadA_RedLight, roadA_YellowLight, roadA_GreenLight,
        output roadB_RedLight, roadB_YellowLight, roadB_GreenLight,
        output faultClear,
        input  fault, faultCode, flashRed, armed, phaseSeconds
    );
    modport slave (
        input  roadA_RedLight, roadA_YellowLight, roadA_GreenLight,
        input  roadB_RedLight, roadB_YellowLight, roadB_GreenLight,
        input  faultClear,
        output fault, faultCode, flashRed, armed, phaseSeconds
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: lamp-side safety checker with flashing-red override; watchdog check enabled by MONITOR_WATCHDOG_EN
module traffic_conflict_monitor #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int MIN_YELLOW  = 1,
    parameter int MIN_ALLRED  = 1,
    parameter int MAX_PHASE   = 15
) (
    input logic CLK100MHZ,
    input logic reset,
    traffic_conflict_monitor_if.slave mon
);
    localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam logic [3:0] MINY = 4'(MIN_YELLOW), MINA = 4'(MIN_ALLRED);
    typedef enum logic [1:0] {INIT, MONITOR, FAULT} state_t;
    state_t state, state_n;
    logic [5:0] cur, prev;
    logic [CW-1:0] cnt;
    logic [3:0] ph;
    logic [2:0] a, b, pa, pb, viol, code_q, code_n;
    logic tick, chg, wd, fault_q, fault_n, flash_q, flash_n;
    function automatic logic seq_bad(input logic [2:0] p, input logic [2:0] c);
        return p != c && !((p == G && c == Y) || (p == Y && c == R) || (p == R && c == G));
    endfunction
    assign {a, b} = cur;
    assign {pa, pb} = prev;
    assign chg = cur != prev;
    assign tick = cnt == CW'(TICK_CYCLES - 1);
`ifdef MONITOR_WATCHDOG_EN
    localparam logic [3:0] MAXP = 4'(MAX_PHASE);
    assign wd = ph >= MAXP && !chg;
`else
    logic unused_max_phase;
    assign unused_max_phase = MAX_PHASE != 0;
    assign wd = 1'b0;
`endif
    // lowest code wins when several checks fire together
    assign viol = !(a == R || b == R)                                    ? 3'd1 :
                  !($onehot(a) && $onehot(b))                            ? 3'd2 :
                  (seq_bad(pa, a) || seq_bad(pb, b))                     ? 3'd3 :
                  ((pa == Y && a != Y) || (pb == Y && b != Y)) && ph < MINY ? 3'd4 :
                  ((pa != G && a == G) || (pb != G && b == G)) && ph < MINA ? 3'd5 :
                  wd                                                     ? 3'd6 : 3'd0;
    always_comb begin
        state_n = state;
        fault_n = fault_q;
        code_n  = code_q;
        flash_n = flash_q;
        if (state == INIT && cur == {R, R}) begin
            state_n = MONITOR;
        end else if (state == MONITOR && viol != 3'd0) begin
            state_n = FAULT;
            fault_n = 1'b1;
            code_n  = viol;
            flash_n = 1'b1;
        end else if (state == FAULT && mon.faultClear) begin
            state_n = INIT;
            fault_n = 1'b0;
            code_n  = 3'd0;
            flash_n = 1'b0;
        end else if (state == FAULT && tick) begin
            flash_n = !flash_q;
        end
    end
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state   <= INIT;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            flash_q <= 1'b0;
            cur     <= '0;
            prev    <= '0;
            cnt     <= '0;
            ph      <= '0;
        end else begin
            state   <= state_n;
            fault_q <= fault_n;
            code_q  <= code_n;
            flash_q <= flash_n;
            cur     <= {mon.roadA_RedLight, mon.roadA_YellowLight, mon.roadA_GreenLight,
                        mon.roadB_RedLight, mon.roadB_YellowLight, mon.roadB_GreenLight};
            prev    <= cur;
            cnt     <= tick ? '0 : cnt + 1'b1;
            ph      <= chg ? 4'd0 : (tick && ph != 4'hf) ? ph + 4'd1 : ph;
        end
    end
    assign mon.fault        = fault_q;
    assign mon.faultCode    = code_q;
    assign mon.flashRed     = flash_q;
    assign mon.armed        = state == MONITOR;
    assign mon.phaseSeconds = ph;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed lamp scenarios checked through a cycle-tagged scoreboard
module tb_traffic_conflict_monitor;
    localparam int TICK = 10;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam logic [9:0] ALL = 10'h3ff, NOPH = 10'h3f0, NOFL = 10'h3e0;
    typedef struct {
        int         when;
        string      name;
        logic [9:0] val;
        logic [9:0] mask;
    } exp_t;
    logic CLK100MHZ = 1'b0;
    logic reset = 1'b1;
    int cyc = 0, cnt_m = 0, n_checks = 0, n_fail = 0;
    exp_t q[$];
    traffic_conflict_monitor_if mon();
    traffic_conflict_monitor #(
        .TICK_CYCLES(TICK), .MIN_YELLOW(1), .MIN_ALLRED(1), .MAX_PHASE(15)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset(reset),
        .mon(mon.slave)
    );
    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) begin
        cyc   <= cyc + 1;
        cnt_m <= reset ? 0 : (cnt_m == TICK - 1 ? 0 : cnt_m + 1);
    end
    wire [9:0] act = {mon.fault, mon.faultCode, mon.armed, mon.flashRed, mon.phaseSeconds};
    function automatic logic [9:0] v(logic f, logic [2:0] c, logic a, logic fl, logic [3:0] p);
        return {f, c, a, fl, p};
    endfunction
    task automatic expect_in(int d, string n, logic [9:0] val, logic [9:0] m);
        exp_t e;
        e.when = cyc + d;
        e.name = n;
        e.val  = val;
        e.mask = m;
        q.push_back(e);
    endtask
    task automatic drive(logic [2:0] a, logic [2:0] b);
        {mon.roadA_RedLight, mon.roadA_YellowLight, mon.roadA_GreenLight} = a;
        {mon.roadB_RedLight, mon.roadB_YellowLight, mon.roadB_GreenLight} = b;
    endtask
    task automatic hold(int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask
    task automatic sync(int p);
        while (cnt_m != p) @(negedge CLK100MHZ);
    endtask
    task automatic step(logic [2:0] a, logic [2:0] b, int n, string name);
        drive(a, b);
        expect_in(n, name, v(0, 0, 1, 0, 0), NOPH);
        hold(n);
    endtask
    task automatic clear_arm();
        mon.faultClear = 1'b1;
        expect_in(1, "clear", v(0, 0, 0, 0, 0), NOPH);
        hold(1);
        mon.faultClear = 1'b0;
        drive(R, R);
        expect_in(2, "rearm", v(0, 0, 1, 0, 0), NOPH);
        hold(20);
    endtask
    initial begin
        forever begin
            @(negedge CLK100MHZ);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].when == cyc) begin
                    n_checks++;
                    if ((act & q[i].mask) !== (q[i].val & q[i].mask)) begin
                        n_fail++;
                        $display("FAIL %s cyc=%0d got=%h want=%h mask=%h",
                                 q[i].name, cyc, act, q[i].val, q[i].mask);
                    end
                    q.delete(i);
                end else if (q[i].when < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s missed at cyc=%0d", q[i].name, q[i].when);
                    q.delete(i);
                end
            end
        end
    end
    initial begin
        repeat (20000) @(posedge CLK100MHZ);
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
    initial begin
        int c;
        drive(3'b000, 3'b000);
        mon.faultClear = 1'b0;
        hold(3);
        expect_in(1, "reset", v(0, 0, 0, 0, 0), ALL);
        hold(1);
        reset = 1'b0;
        drive(R, R);
        expect_in(1, "init_not_armed", v(0, 0, 0, 0, 0), NOPH);
        expect_in(2, "armed", v(0, 0, 1, 0, 0), NOPH);
        hold(20);
        sync(8);
        drive(G, R);
        expect_in(2, "chg_tick_clear", v(0, 0, 1, 0, 0), ALL);
        expect_in(40, "greenA", v(0, 0, 1, 0, 0), NOPH);
        hold(40);
        step(Y, R, 20, "yellowA");
        step(R, R, 20, "redA");
        step(R, G, 40, "greenB");
        step(R, Y, 20, "yellowB");
        step(R, R, 20, "redB");
        sync(0);
        drive(G, G);
        expect_in(1, "conflict_pre", v(0, 0, 1, 0, 0), NOPH);
        expect_in(2, "conflict", v(1, 1, 0, 1, 0), NOPH);
        expect_in(10, "flash_toggle0", v(1, 1, 0, 0, 0), NOPH);
        expect_in(19, "flash_hold0", v(1, 1, 0, 0, 0), NOPH);
        expect_in(20, "flash_toggle1", v(1, 1, 0, 1, 0), NOPH);
        hold(20);
        drive(3'b000, 3'b000);
        expect_in(3, "code_latched", v(1, 1, 0, 0, 0), NOFL);
        hold(5);
        clear_arm();
        step(G, R, 20, "greenA_skip");
        drive(R, R);
        expect_in(1, "skip_pre", v(0, 0, 1, 0, 0), NOPH);
        expect_in(2, "skip_yellow", v(1, 3, 0, 1, 0), NOPH);
        hold(5);
        reset = 1'b1;
        expect_in(1, "reset_in_fault", v(0, 0, 0, 0, 0), ALL);
        hold(1);
        reset = 1'b0;
        expect_in(2, "rearm_after_reset", v(0, 0, 1, 0, 0), NOPH);
        hold(20);
        step(G, R, 20, "greenA_short");
        sync(9);
        drive(Y, R);
        hold(3);
        drive(R, R);
        expect_in(1, "short_pre", v(0, 0, 1, 0, 0), NOPH);
        expect_in(2, "short_yellow", v(1, 4, 0, 1, 0), NOPH);
        hold(5);
        clear_arm();
        drive(3'b000, R);
        expect_in(2, "lamp_dark", v(1, 2, 0, 1, 0), NOPH);
        hold(3);
        clear_arm();
        drive(3'b101, G);
        expect_in(2, "priority", v(1, 1, 0, 1, 0), NOPH);
        hold(3);
        clear_arm();
        sync(8);
        drive(G, R);
        c = cyc;
`ifdef MONITOR_WATCHDOG_EN
        expect_in(152, "wd_pre", v(0, 0, 1, 0, 15), ALL);
        expect_in(153, "watchdog", v(1, 6, 0, 1, 0), NOPH);
        expect_in(160, "wd_latched", v(1, 6, 0, 0, 0), NOFL);
`else
        expect_in(160, "no_watchdog", v(0, 0, 1, 0, 15), ALL);
`endif
        hold(160);
        mon.faultClear = 1'b1;
`ifdef MONITOR_WATCHDOG_EN
        expect_in(1, "wd_clear", v(0, 0, 0, 0, 0), NOPH);
`else
        expect_in(1, "clear_ignored", v(0, 0, 1, 0, 15), ALL);
`endif
        hold(1);
        mon.faultClear = 1'b0;
        drive(R, R);
`ifdef MONITOR_WATCHDOG_EN
        expect_in(2, "wd_rearm", v(0, 0, 1, 0, 0), NOPH);
`else
        expect_in(2, "skip_after_hold", v(1, 3, 0, 1, 0), NOPH);
`endif
        hold(5);
        if (cyc - c < 165) begin
            n_checks++;
            n_fail++;
            $display("FAIL hold_length got=%0d want>=165", cyc - c);
        end
        if (q.size() != 0) begin
            n_checks += q.size();
            n_fail += q.size();
            $display("FAIL pending got=%0d want=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
